// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared definitions for the fifo read controller: default widths, buffer
// occupancy encoding and a counter-width helper.
package pop_ctrl_pkg;

    localparam int DEF_DW      = 16;
    localparam int DEF_PKT_LEN = 8;
    localparam int PKT_CNT_W   = 16;

    // Encoding doubles as the occupancy count, so it can be used in arithmetic.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // Width of a 0..n-1 counter; never zero, so PKT_LEN = 1 still gets a real register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_pop_ctrl_if.sv
// Valid/ready output stream of the fifo read controller, with packet framing.
import pop_ctrl_pkg::*;

interface fifo_pop_ctrl_if #(parameter int DW = DEF_DW) ();

    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;

    modport master (
        output o_data,
        output o_valid,
        output o_last,
        input  o_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_last,
        output o_ready
    );

endinterface

// File: rtl/fifo_pop_ctrl_skid_buf2.sv
// Two-entry in-order skid buffer: slot0 is always the head, slot1 the tail.
module skid_buf2
    import pop_ctrl_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output buf_state_e    occ
);

    buf_state_e    state;
    buf_state_e    state_n;
    logic [DW-1:0] slot0;
    logic [DW-1:0] slot1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // The caller never pops when empty and never pushes into TWO without a pop.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_n = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_n = ST_TWO;
                end else if (pop && !push) begin
                    state_n = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop && !push) begin
                    state_n = ST_ONE;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (push) begin
                        slot0 <= din;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        slot0 <= din;
                    end else if (push) begin
                        slot1 <= din;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        slot0 <= slot1;
                        if (push) begin
                            slot1 <= din;
                        end
                    end
                end
                default: begin
                    slot0 <= slot0;
                end
            endcase
        end
    end

    assign head = slot0;
    assign occ  = state;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Drains the synchronous fifo into a valid/ready stream through a 2-entry skid
// buffer, frames fixed-length packets, counts them and flags fifo-side errors.
module fifo_pop_ctrl
    import pop_ctrl_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int PKT_LEN = DEF_PKT_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic                 fifo_under,
    output logic                 fifo_rd,
    input  logic [DW-1:0]        fifo_dout,
    input  logic                 fifo_valid,
    fifo_pop_ctrl_if.master      strm,
    output logic [PKT_CNT_W-1:0] pkt_cnt,
    output logic                 err
);

    localparam int             WCW   = cnt_width(PKT_LEN);
    localparam logic [WCW-1:0] WLAST = WCW'(PKT_LEN - 1);

    logic          inflight;
    logic          push;
    logic          pop;
    logic          ovf;
    logic          push_ok;
    logic          unreq;
    buf_state_e    occ;
    logic [1:0]    occ_v;
    logic [2:0]    demand;
    logic [2:0]    room;
    logic [DW-1:0] head;
    logic [WCW-1:0] wcnt;

    assign occ_v = occ;

    assign strm.o_valid = (occ != ST_EMPTY);
    assign strm.o_data  = head;
    assign strm.o_last  = strm.o_valid && (wcnt == WLAST);

    assign pop     = strm.o_valid && strm.o_ready;
    assign push    = fifo_valid && inflight;
    assign unreq   = fifo_valid && !inflight;
    assign ovf     = push && (occ == ST_TWO) && !pop;
    assign push_ok = push && !ovf;

    // occ + inflight - pop < 2, rearranged so nothing underflows.
    assign demand  = 3'(occ_v) + 3'(inflight);
    assign room    = 3'd2 + 3'(pop);
    assign fifo_rd = rst && !fifo_empty && (demand < room);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd;
        end
    end

    skid_buf2 #(.DW(DW)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (push_ok),
        .pop  (pop),
        .din  (fifo_dout),
        .head (head),
        .occ  (occ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt    <= '0;
            pkt_cnt <= '0;
        end else if (pop) begin
            if (wcnt == WLAST) begin
                wcnt    <= '0;
                pkt_cnt <= pkt_cnt + 1'b1;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (fifo_under || unreq || ovf) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Scoreboard bench for fifo_pop_ctrl: behavioural fifo models feed two builds
// (PKT_LEN 8 and 1); monitors check every accepted word against queued expectations.
module tb_fifo_pop_ctrl;
    import pop_ctrl_pkg::*;

    localparam int DW = 16;
    localparam int PL = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // build 0: PKT_LEN = 8
    logic          empty0 = 1'b1;
    logic          under0 = 1'b0;
    logic          rd0;
    logic          valid0 = 1'b0;
    logic [DW-1:0] dout0 = '0;
    logic [15:0]   pkt0;
    logic          err0;
    logic          rdc0;
    logic          spur0 = 1'b0;
    logic [DW-1:0] fq0[$];
    logic [DW-1:0] exp_d0[$];
    logic          exp_l0[$];
    int            sent0 = 0;

    // build 1: PKT_LEN = 1
    logic          empty1 = 1'b1;
    logic          rd1;
    logic          valid1 = 1'b0;
    logic [DW-1:0] dout1 = '0;
    logic [15:0]   pkt1;
    logic          err1;
    logic          rdc1;
    logic [DW-1:0] fq1[$];
    logic [DW-1:0] exp_d1[$];
    logic          exp_l1[$];
    int            sent1 = 0;

    fifo_pop_ctrl_if #(.DW(DW)) s0 ();
    fifo_pop_ctrl_if #(.DW(DW)) s1 ();

    fifo_pop_ctrl #(.DW(DW), .PKT_LEN(PL)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_under(under0),
        .fifo_rd(rd0), .fifo_dout(dout0), .fifo_valid(valid0),
        .strm(s0), .pkt_cnt(pkt0), .err(err0)
    );

    fifo_pop_ctrl #(.DW(DW), .PKT_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_under(1'b0),
        .fifo_rd(rd1), .fifo_dout(dout1), .fifo_valid(valid1),
        .strm(s1), .pkt_cnt(pkt1), .err(err1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Fifo models: a read strobe seen before an edge returns the word after it.
    always begin
        @(negedge clk);
        rdc0 = rd0;
        @(posedge clk);
        #1;
        if (!rst) begin
            fq0.delete();
            valid0 = 1'b0;
        end else if (rdc0 && fq0.size() > 0) begin
            dout0  = fq0.pop_front();
            valid0 = 1'b1;
        end else if (spur0) begin
            dout0  = 16'hDEAD;
            valid0 = 1'b1;
        end else begin
            valid0 = 1'b0;
        end
        #1;
        empty0 = (fq0.size() == 0);
    end

    always begin
        @(negedge clk);
        rdc1 = rd1;
        @(posedge clk);
        #1;
        if (!rst) begin
            fq1.delete();
            valid1 = 1'b0;
        end else if (rdc1 && fq1.size() > 0) begin
            dout1  = fq1.pop_front();
            valid1 = 1'b1;
        end else begin
            valid1 = 1'b0;
        end
        #1;
        empty1 = (fq1.size() == 0);
    end

    // Monitor 0: ordering, framing, packet count and stall stability.
    int            done0 = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            done0      = 0;
            prev_stall = 1'b0;
        end else begin
            chk("pkt_cnt", 32'(pkt0), 32'((done0 / PL) % 65536));
            if (prev_stall) begin
                chk("hold_valid", 32'(s0.o_valid), 32'd1);
                chk("hold_data", 32'(s0.o_data), 32'(prev_d));
                chk("hold_last", 32'(s0.o_last), 32'(prev_l));
            end
            if (s0.o_valid && s0.o_ready) begin
                if (exp_d0.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_word got=%0h expected=none", s0.o_data);
                end else begin
                    chk("data", 32'(s0.o_data), 32'(exp_d0.pop_front()));
                    chk("last", 32'(s0.o_last), 32'(exp_l0.pop_front()));
                end
                done0++;
            end
            prev_stall = s0.o_valid && !s0.o_ready;
            prev_d     = s0.o_data;
            prev_l     = s0.o_last;
        end
    end

    // Monitor 1: the single-word-packet build.
    always @(negedge clk) begin
        if (rst && s1.o_valid && s1.o_ready) begin
            if (exp_d1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_word1 got=%0h expected=none", s1.o_data);
            end else begin
                chk("data1", 32'(s1.o_data), 32'(exp_d1.pop_front()));
                chk("last1", 32'(s1.o_last), 32'(exp_l1.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [DW-1:0] d);
        fq0.push_back(d);
        exp_d0.push_back(d);
        exp_l0.push_back((sent0 % PL) == PL - 1);
        sent0++;
    endtask

    task automatic send1(input logic [DW-1:0] d);
        fq1.push_back(d);
        exp_d1.push_back(d);
        exp_l1.push_back((sent1 % 1) == 0);
        sent1++;
    endtask

    task automatic drain0();
        int n;
        n = 0;
        s0.o_ready = 1'b1;
        while (exp_d0.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_d0.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fq0.delete();
        exp_d0.delete();
        exp_l0.delete();
        sent0 = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int k;
        int nv;
        int cnt;
        int n;
        s0.o_ready = 1'b0;
        s1.o_ready = 1'b0;
        repeat (3) tick();
        chk("rst_rd", 32'(rd0), 32'd0);
        chk("rst_valid", 32'(s0.o_valid), 32'd0);
        chk("rst_data", 32'(s0.o_data), 32'd0);
        chk("rst_last", 32'(s0.o_last), 32'd0);
        chk("rst_pkt", 32'(pkt0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        rst = 1'b1;
        tick();

        // 1..9 with consumer always ready
        s0.o_ready = 1'b1;
        for (int i = 1; i <= 9; i++) send0(16'(i));
        k = 0;
        @(negedge clk);
        while (!s0.o_valid && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk("first_latency", 32'(k), 32'd2);
        nv = 0;
        for (int j = 0; j < 9; j++) begin
            if (s0.o_valid) nv++;
            if (j < 8) @(negedge clk);
        end
        chk("no_bubble", 32'(nv), 32'd9);
        drain0();
        chk("t1_pkt", 32'(pkt0), 32'd1);
        chk("t1_err", 32'(err0), 32'd0);

        // backpressure: 5-cycle stall with 4 words queued
        do_reset();
        s0.o_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send0(16'h0040 + 16'(i));
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (rd0) cnt++;
        end
        chk("stall_rd_pulses", 32'(cnt), 32'd2);
        @(posedge clk);
        #1;
        drain0();
        chk("t2_pkt", 32'(pkt0), 32'd0);

        // ready toggling every cycle, 16 words
        do_reset();
        for (int i = 1; i <= 16; i++) send0(16'h0100 + 16'(i));
        n = 0;
        while (exp_d0.size() != 0 && n < 300) begin
            s0.o_ready = ~s0.o_ready;
            tick();
            n++;
        end
        drain0();
        chk("t3_pkt", 32'(pkt0), 32'd2);

        // unrequested fifo_valid while idle
        do_reset();
        @(posedge clk);
        #3 spur0 = 1'b1;
        @(posedge clk);
        #3 spur0 = 1'b0;
        repeat (3) tick();
        chk("err_unreq", 32'(err0), 32'd1);
        chk("unreq_valid", 32'(s0.o_valid), 32'd0);

        // fifo_under pulse during a live stream
        do_reset();
        chk("err_cleared", 32'(err0), 32'd0);
        s0.o_ready = 1'b1;
        for (int i = 1; i <= 12; i++) send0(16'h0200 + 16'(i));
        tick();
        tick();
        under0 = 1'b1;
        tick();
        under0 = 1'b0;
        drain0();
        chk("err_under", 32'(err0), 32'd1);
        send0(16'h020D);
        drain0();
        repeat (5) tick();
        chk("err_sticky", 32'(err0), 32'd1);

        // reset while TWO is occupied and 5 words into a packet
        s0.o_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send0(16'h0300 + 16'(i));
        repeat (4) tick();
        chk("pre_rst_valid", 32'(s0.o_valid), 32'd1);
        chk("pre_rst_pkt", 32'(pkt0), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(s0.o_valid), 32'd0);
        chk("arst_data", 32'(s0.o_data), 32'd0);
        chk("arst_last", 32'(s0.o_last), 32'd0);
        chk("arst_pkt", 32'(pkt0), 32'd0);
        chk("arst_err", 32'(err0), 32'd0);
        chk("arst_rd", 32'(rd0), 32'd0);
        fq0.delete();
        exp_d0.delete();
        exp_l0.delete();
        sent0 = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) send0(16'h0400 + 16'(i));
        drain0();
        chk("post_rst_pkt", 32'(pkt0), 32'd1);

        // randomized traffic and backpressure
        do_reset();
        repeat (400) begin
            s0.o_ready = ($urandom_range(0, 3) != 0);
            if (fq0.size() < 6 && $urandom_range(0, 1) == 1) send0(16'($urandom));
            tick();
        end
        drain0();
        chk("rand_pkt", 32'(pkt0), 32'((sent0 / PL) % 65536));
        chk("rand_err", 32'(err0), 32'd0);

        // single-word packets
        s1.o_ready = 1'b1;
        for (int i = 1; i <= 3; i++) send1(16'h0500 + 16'(i));
        n = 0;
        while (exp_d1.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("p1_left", 32'(exp_d1.size()), 32'd0);
        chk("p1_pkt", 32'(pkt1), 32'd3);
        chk("p1_err", 32'(err1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
